// File: rtl/uartb_rx_core.sv
// UART 8N1 receiver core with a programmable baud divider and an optional
// burst mode that packs four received bytes into one 32-bit word.
//
// state | meaning
// IDLE  | line idle, waiting for a synchronized falling edge
// START | counting to mid start bit to reject glitches
// DATA  | sampling 8 data bits LSB-first at mid-bit
// STOP  | sampling the stop bit, byte completes when the count expires
module uartb_rx_core #(
  parameter int BAUDBITS = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d,
  input  logic        wrbaud,
  input  logic        rxd,
  input  logic        rd,
  output logic [31:0] q,
  output logic        dv,
  output logic        fe,
  output logic        ove,
  output logic        busy,
  output logic [1:0]  nbyte
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [BAUDBITS-1:0] CNT_ONE = 1;

  state_t              state, state_nx;
  logic [1:0]          sync;
  logic                rx_s, rx_d, fall;
  logic [BAUDBITS-1:0] divider, cnt;
  logic                mode;
  logic [2:0]          bit_idx;
  logic [7:0]          shreg;
  logic [23:0]         asm_word;
  logic                err_sticky;
  logic                cnt_zero, byte_done, word_done;

  assign rx_s      = sync[1];
  assign fall      = rx_d & ~rx_s;
  assign cnt_zero  = (cnt == '0);
  assign word_done = byte_done & (~mode | (nbyte == 2'd3));

  // Synchronizer and edge register reset high so an idle line never looks like a start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      rx_d <= 1'b1;
    end else begin
      sync <= {sync[0], rxd};
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divider <= '0;
      mode    <= 1'b0;
    end else if (wrbaud) begin
      divider <= d[BAUDBITS-1:0];
      mode    <= d[31];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (fall) state_nx = START;
      START: if (cnt_zero) state_nx = rx_s ? IDLE : DATA;
      DATA:  if (cnt_zero && bit_idx == 3'd7) state_nx = STOP;
      STOP:  if (cnt_zero) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    byte_done = (state == STOP) && cnt_zero;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: if (fall) cnt <= divider >> 1;
        START:
          if (cnt_zero) begin
            cnt     <= divider;
            bit_idx <= '0;
          end else cnt <= cnt - CNT_ONE;
        DATA:
          if (cnt_zero) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= divider;
            bit_idx <= bit_idx + 3'd1;
          end else cnt <= cnt - CNT_ONE;
        STOP: if (!cnt_zero) cnt <= cnt - CNT_ONE;
        default: cnt <= '0;
      endcase
    end
  end

  // Burst assembly; a divider/mode write restarts word packing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nbyte      <= '0;
      err_sticky <= 1'b0;
      asm_word   <= '0;
    end else if (wrbaud) begin
      nbyte      <= '0;
      err_sticky <= 1'b0;
      asm_word   <= '0;
    end else if (byte_done && mode) begin
      if (nbyte == 2'd3) begin
        nbyte      <= '0;
        err_sticky <= 1'b0;
      end else begin
        case (nbyte)
          2'd0:    asm_word[7:0]   <= shreg;
          2'd1:    asm_word[15:8]  <= shreg;
          default: asm_word[23:16] <= shreg;
        endcase
        err_sticky <= err_sticky | ~rx_s;
        nbyte      <= nbyte + 2'd1;
      end
    end
  end

  // Completion takes priority over a simultaneous read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      dv  <= 1'b0;
      fe  <= 1'b0;
      ove <= 1'b0;
    end else if (word_done) begin
      q   <= mode ? {shreg, asm_word} : {24'h0, shreg};
      dv  <= 1'b1;
      fe  <= mode ? (err_sticky | ~rx_s) : ~rx_s;
      ove <= dv & ~rd;
    end else if (rd) begin
      dv  <= 1'b0;
      fe  <= 1'b0;
      ove <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uartb_rx_core.sv
// Self-checking bench for uartb_rx_core: fixed vector table, hand-written
// corner sequences, and randomized frames against a byte-level model.
module tb_uartb_rx_core;

  logic        clk = 1'b0;
  logic        rst, wrbaud, rxd, rd;
  logic [31:0] d, q;
  logic        dv, fe, ove, busy;
  logic [1:0]  nbyte;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_div  = 3;

  // reference model state
  logic [31:0] m_q;
  bit          m_dv, m_fe, m_ove, m_mode, m_err;
  int          m_nb;
  logic [7:0]  m_lane [4];

  typedef struct {
    bit          wr;
    bit          mode;
    bit          rd_first;
    logic [7:0]  data;
    bit          stop_ok;
    logic [31:0] q;
    bit          dv, fe, ove;
    logic [1:0]  nb;
  } vec_t;

  vec_t tab [17];

  always #5 clk = ~clk;

  uartb_rx_core #(.BAUDBITS(9)) dut (
    .clk(clk), .rst(rst), .d(d), .wrbaud(wrbaud), .rxd(rxd), .rd(rd),
    .q(q), .dv(dv), .fe(fe), .ove(ove), .busy(busy), .nbyte(nbyte)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] eq, input bit edv,
                           input bit efe, input bit eove, input logic [1:0] enb);
    cmp({tag, " q"}, q, eq);
    cmp({tag, " dv"}, {31'b0, dv}, {31'b0, edv});
    cmp({tag, " fe"}, {31'b0, fe}, {31'b0, efe});
    cmp({tag, " ove"}, {31'b0, ove}, {31'b0, eove});
    cmp({tag, " nbyte"}, {30'b0, nbyte}, {30'b0, enb});
  endtask

  task automatic write_baud(input int div, input bit mode);
    @(negedge clk);
    d = 32'(div);
    d[31] = mode;
    wrbaud = 1'b1;
    @(negedge clk);
    wrbaud = 1'b0;
    d = '0;
    cur_div = div;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Drives the first nbits line bits (start, 8 data, stop); called at a negedge
  task automatic send_bits(input logic [7:0] b, input bit stop_ok, input int nbits);
    logic [9:0] frame;
    frame = {stop_ok, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rxd = frame[i];
      repeat (cur_div + 1) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    send_bits(b, stop_ok, 10);
    rxd = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    cmp({tag, " idle"}, {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic model_reset();
    m_q = '0; m_dv = 0; m_fe = 0; m_ove = 0; m_mode = 0; m_err = 0; m_nb = 0;
    for (int i = 0; i < 4; i++) m_lane[i] = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!m_mode) begin
      m_ove = m_dv;
      m_q   = {24'h0, b};
      m_dv  = 1;
      m_fe  = !stop_ok;
    end else begin
      m_lane[m_nb] = b;
      m_err = m_err | !stop_ok;
      if (m_nb == 3) begin
        m_q = 32'(m_lane[0]) + (32'(m_lane[1]) << 8) + (32'(m_lane[2]) << 16) + (32'(m_lane[3]) << 24);
        m_ove = m_dv;
        m_dv  = 1;
        m_fe  = m_err;
        m_err = 0;
        m_nb  = 0;
      end else m_nb = m_nb + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b1; wrbaud = 1'b0; rxd = 1'b1; rd = 1'b0; d = '0;

    tab[0]  = '{1, 0, 0, 8'h41, 1, 32'h00000041, 1, 0, 0, 2'd0};
    tab[1]  = '{0, 0, 0, 8'h11, 1, 32'h00000011, 1, 0, 1, 2'd0};
    tab[2]  = '{0, 0, 0, 8'h22, 1, 32'h00000022, 1, 0, 1, 2'd0};
    tab[3]  = '{0, 0, 1, 8'h33, 0, 32'h00000033, 1, 1, 0, 2'd0};
    tab[4]  = '{0, 0, 1, 8'h44, 1, 32'h00000044, 1, 0, 0, 2'd0};
    tab[5]  = '{1, 1, 1, 8'h78, 1, 32'h00000044, 0, 0, 0, 2'd1};
    tab[6]  = '{0, 1, 0, 8'h56, 1, 32'h00000044, 0, 0, 0, 2'd2};
    tab[7]  = '{0, 1, 0, 8'h34, 1, 32'h00000044, 0, 0, 0, 2'd3};
    tab[8]  = '{0, 1, 0, 8'h12, 1, 32'h12345678, 1, 0, 0, 2'd0};
    tab[9]  = '{0, 1, 1, 8'hAA, 1, 32'h12345678, 0, 0, 0, 2'd1};
    tab[10] = '{0, 1, 0, 8'hBB, 0, 32'h12345678, 0, 0, 0, 2'd2};
    tab[11] = '{0, 1, 0, 8'hCC, 1, 32'h12345678, 0, 0, 0, 2'd3};
    tab[12] = '{0, 1, 0, 8'hDD, 1, 32'hDDCCBBAA, 1, 1, 0, 2'd0};
    tab[13] = '{0, 1, 0, 8'h01, 1, 32'hDDCCBBAA, 1, 1, 0, 2'd1};
    tab[14] = '{0, 1, 0, 8'h02, 1, 32'hDDCCBBAA, 1, 1, 0, 2'd2};
    tab[15] = '{0, 1, 0, 8'h03, 1, 32'hDDCCBBAA, 1, 1, 0, 2'd3};
    tab[16] = '{0, 1, 0, 8'h04, 1, 32'h04030201, 1, 0, 1, 2'd0};

    // outputs while reset is held
    repeat (3) @(negedge clk);
    check_out("reset", 32'h0, 0, 0, 0, 2'd0);
    cmp("reset busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      if (tab[i].wr) write_baud(3, tab[i].mode);
      if (tab[i].rd_first) pulse_rd();
      send_frame(tab[i].data, tab[i].stop_ok);
      wait_idle($sformatf("vec%0d", i));
      check_out($sformatf("vec%0d", i), tab[i].q, tab[i].dv, tab[i].fe, tab[i].ove, tab[i].nb);
    end

    // overrun then read
    write_baud(3, 0);
    send_frame(8'h11, 1); wait_idle("ovr1");
    send_frame(8'h22, 1); wait_idle("ovr2");
    check_out("ovr", 32'h22, 1, 0, 1, 2'd0);
    pulse_rd();
    @(negedge clk);
    check_out("rd_clear", 32'h22, 0, 0, 0, 2'd0);

    // read strobe landing on the completion cycle
    send_frame(8'h66, 1); wait_idle("pre_rdc");
    k = 3 + (cur_div >> 1) + 1 + 9 * (cur_div + 1);
    fork
      send_frame(8'h77, 1);
      begin
        repeat (k - 1) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    wait_idle("rdc");
    check_out("rd_collide", 32'h77, 1, 0, 0, 2'd0);

    // half-bit glitch is a false start
    write_baud(7, 0);
    send_frame(8'h5A, 1); wait_idle("pre_glitch");
    check_out("pre_glitch", 32'h5A, 1, 0, 1, 2'd0);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    cmp("glitch busy", {31'b0, busy}, 32'd1);
    wait_idle("glitch");
    check_out("glitch", 32'h5A, 1, 0, 1, 2'd0);

    // asynchronous reset in the middle of the second burst byte
    write_baud(3, 1);
    send_frame(8'h78, 1); wait_idle("rst_b0");
    send_bits(8'h56, 1, 4);
    #2 rst = 1'b1;
    #1;
    check_out("async_rst", 32'h0, 0, 0, 0, 2'd0);
    cmp("async_rst busy", {31'b0, busy}, 32'd0);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    write_baud(3, 1);
    send_frame(8'h78, 1); wait_idle("post_rst0");
    cmp("post_rst nb1", {30'b0, nbyte}, 32'd1);
    send_frame(8'h56, 1); wait_idle("post_rst1");
    send_frame(8'h34, 1); wait_idle("post_rst2");
    cmp("post_rst dv", {31'b0, dv}, 32'd0);
    send_frame(8'h12, 1); wait_idle("post_rst3");
    check_out("post_rst", 32'h12345678, 1, 0, 0, 2'd0);

    // randomized frames against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      bit         s;
      if (i == 0 || $urandom_range(0, 7) == 0) begin
        int  nd;
        bit  nm;
        nd = $urandom_range(3, 12);
        nm = $urandom_range(0, 1);
        write_baud(nd, nm);
        m_mode = nm; m_nb = 0; m_err = 0;
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_rd();
        m_dv = 0; m_fe = 0; m_ove = 0;
      end
      b = 8'($urandom);
      s = ($urandom_range(0, 5) != 0);
      send_frame(b, s);
      wait_idle($sformatf("rnd%0d", i));
      model_byte(b, s);
      check_out($sformatf("rnd%0d", i), m_q, m_dv, m_fe, m_ove, 2'(m_nb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uartb_rx_core.md
UARTB_RX_CORE -- requirements
Module: uartb_rx_core

Interface
REQ-001 SHALL have parameter BAUDBITS, default 9, giving the width of the baud divider.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port d  input  32  configuration word: d[BAUDBITS-1:0] is the divider, d[31] is MODE (1 burst, 0 normal).
REQ-005 SHALL have port wrbaud  input  1  write strobe for divider and MODE.
REQ-006 SHALL have port rxd  input  1  asynchronous serial input, 8N1, idle high.
REQ-007 SHALL have port rd  input  1  read strobe; clears dv, ove and fe.
REQ-008 SHALL have port q  output  32  received word register.
REQ-009 SHALL have port dv  output  1  word valid flag.
REQ-010 SHALL have port fe  output  1  framing error flag for the word in q.
REQ-011 SHALL have port ove  output  1  overrun flag.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is outside IDLE.
REQ-013 SHALL have port nbyte  output  2  number of bytes already packed into the word being assembled.

Function
REQ-014 SHALL pass rxd through a 2-flop synchronizer; all sampling and edge detection use the synchronized value only.
REQ-015 SHALL define the bit period as divider+1 clocks; a wrbaud pulse loads divider and MODE in the next cycle.
REQ-016 SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-017 IDLE: on a synchronized 1->0 transition, SHALL load the bit counter with divider>>1 and enter START.
REQ-018 START: when the counter reaches 0, SHALL return to IDLE if the sample is 1 (false start, no flags changed); otherwise SHALL reload divider and enter DATA.
REQ-019 DATA: each time the counter reaches 0, SHALL shift the sample in LSB-first and reload divider; after the 8th bit it SHALL enter STOP.
REQ-020 STOP: when the counter reaches 0, SHALL sample the stop bit, assert byte-complete for 1 cycle, and return to IDLE in the same cycle.
REQ-021 Normal mode (MODE=0) byte-complete: SHALL set q={24'h0,byte}, dv=1, fe=~stop, ove=old dv, and keep nbyte=0.
REQ-022 Burst mode (MODE=1) byte-complete: SHALL place the byte into lane nbyte (byte 0 -> q bits [7:0] ... byte 3 -> bits [31:24]) of an internal assembly register, OR ~stop into a sticky word-error bit, and increment nbyte.
REQ-023 Burst mode, byte with nbyte=3: SHALL copy the assembled word to q, set dv=1, set fe=sticky error including this byte, set ove=old dv, and clear nbyte and sticky error (wrap 3->0).
REQ-024 q SHALL change only on word completion; partial burst words SHALL NOT be visible on q.
REQ-025 rd without a simultaneous completion SHALL clear dv, ove and fe next cycle; q SHALL be kept.
REQ-026 rd coinciding with completion: completion SHALL win, giving dv=1, ove=0 and fe per the new word.
REQ-027 Overrun SHALL overwrite q with the new word.
REQ-028 wrbaud SHALL clear nbyte and the assembly state; a frame in progress SHALL continue with the new divider.
REQ-029 busy SHALL be 1 in START, DATA and STOP.

Reset
REQ-030 While rst=1, SHALL force state=IDLE, synchronizer=2'b11, divider=0, MODE=0, bit counter=0, nbyte=0, sticky error=0, q=0, dv=0, fe=0, ove=0, busy=0, all asynchronously.
REQ-031 When rst is released mid-frame, SHALL ignore the remainder of that frame until a fresh 1->0 edge is seen in IDLE.

Verification
REQ-032 Divider=3, MODE=0, send byte 0x41 with a valid stop -> q=0x00000041, dv=1, fe=0, ove=0, nbyte=0.
REQ-033 Divider=3, MODE=1, send 0x78,0x56,0x34,0x12 -> dv stays 0 for the first 3 bytes (nbyte 1,2,3), then q=0x12345678, dv=1, nbyte=0.
REQ-034 Burst mode, 2nd byte sent with stop=0 -> after the 4th byte fe=1 and dv=1; a following clean word gives fe=0.
REQ-035 Two normal-mode bytes 0x11,0x22 with no rd -> q=0x22, ove=1; then rd -> dv=0, ove=0, fe=0, q=0x22.
REQ-036 Glitch of 1 bit-half low on rxd (divider=7) -> false start, dv unchanged, busy returns to 0.
REQ-037 rst asserted during the 2nd burst byte -> all outputs 0 immediately; the next full 4-byte burst is received correctly, with MODE rewritten first.
